// File: rtl/mock_uart_rx_pkg.sv
// rtl/mock_uart_rx_pkg.sv - register map and STATUS layout for the mock UART receiver
package mock_uart_rx_pkg;

  localparam logic [1:0] RX_DATA_OFF   = 2'd0;
  localparam logic [1:0] RX_STATUS_OFF = 2'd1;
  localparam logic [1:0] RX_CTRL_OFF   = 2'd2;

  localparam int STATUS_VALID_BIT = 0;
  localparam int STATUS_OVF_BIT   = 1;
  localparam int STATUS_COUNT_LSB = 8;

  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  count;
    logic [5:0]  rsvd_lo;
    logic        overflow;
    logic        valid;
  } rx_status_t;

  // Deep FIFOs (256 entries) need the 9th count bit folded into 8'hFF.
  function automatic logic [7:0] sat_count8(input logic [8:0] c);
    return c[8] ? 8'hFF : c[7:0];
  endfunction

endpackage

// File: rtl/mock_uart_rx_if.sv
// rtl/mock_uart_rx_if.sv - device-port and host-injection signals of the mock UART receiver
interface mock_uart_rx_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    M_DEVICE_strobe_i;
  logic [31:0]             M_DEVICE_addr_i;
  logic                    M_DEVICE_rw_i;
  logic [DATA_WIDTH/8-1:0] M_DEVICE_byte_enable_i;
  logic [DATA_WIDTH-1:0]   M_DEVICE_core2dev_data_i;
  logic                    M_DEVICE_data_ready_o;
  logic [DATA_WIDTH-1:0]   M_DEVICE_dev2core_data_o;
  logic                    host_valid_i;
  logic [7:0]              host_data_i;
  logic                    host_ready_o;

  modport master (
    output M_DEVICE_strobe_i, M_DEVICE_addr_i, M_DEVICE_rw_i,
    output M_DEVICE_byte_enable_i, M_DEVICE_core2dev_data_i,
    output host_valid_i, host_data_i,
    input  M_DEVICE_data_ready_o, M_DEVICE_dev2core_data_o, host_ready_o
  );

  modport slave (
    input  M_DEVICE_strobe_i, M_DEVICE_addr_i, M_DEVICE_rw_i,
    input  M_DEVICE_byte_enable_i, M_DEVICE_core2dev_data_i,
    input  host_valid_i, host_data_i,
    output M_DEVICE_data_ready_o, M_DEVICE_dev2core_data_o, host_ready_o
  );
endinterface

// File: rtl/rx_sync_fifo.sv
// rtl/rx_sync_fifo.sv - synchronous FIFO; a push while full is accepted when a pop frees the slot
module rx_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mock_uart_rx.sv
// rtl/mock_uart_rx.sv - polled receive-side mock UART on the core device port
// MOCK_UART_RX_IRQ_EN adds the CTRL register and the registered irq_o output.
module mock_uart_rx
  import mock_uart_rx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hC000_0100,
  parameter int          FIFO_DEPTH = 16,
  parameter int          DATA_WIDTH = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mock_uart_rx_if.slave  bus
`ifdef MOCK_UART_RX_IRQ_EN
  ,
  output logic           irq_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  w_hit;
  logic [1:0]            w_off;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [7:0]            w_head;
  logic [CW-1:0]         w_count;
  logic                  w_ovf_set;
  logic                  w_ovf_clr;
  rx_status_t            w_status;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused_ok;

  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_overflow;

  assign w_hit = bus.M_DEVICE_strobe_i && (bus.M_DEVICE_addr_i[31:4] == BASE_ADDR[31:4]);
  assign w_off = bus.M_DEVICE_addr_i[3:2];
  assign w_rd  = w_hit && !bus.M_DEVICE_rw_i;
  assign w_wr  = w_hit && bus.M_DEVICE_rw_i;
  assign w_pop = w_rd && (w_off == RX_DATA_OFF) && !w_empty;

  // A byte arriving on a full FIFO is kept only if this cycle's pop frees a slot.
  assign w_ovf_set = bus.host_valid_i && w_full && !w_pop;
  assign w_ovf_clr = w_wr && (w_off == RX_STATUS_OFF) && bus.M_DEVICE_byte_enable_i[0]
                     && bus.M_DEVICE_core2dev_data_i[STATUS_OVF_BIT];

  assign w_unused_ok = ^{bus.M_DEVICE_addr_i[1:0], bus.M_DEVICE_byte_enable_i,
                         bus.M_DEVICE_core2dev_data_i};

  rx_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (bus.host_valid_i),
    .i_data  (bus.host_data_i),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

`ifdef MOCK_UART_RX_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && (w_off == RX_CTRL_OFF) && bus.M_DEVICE_byte_enable_i[0]) begin
        r_irq_en <= bus.M_DEVICE_core2dev_data_i[0];
      end
      r_irq <= r_irq_en && !w_empty;
    end
  end

  assign irq_o = r_irq;
`endif

  always_comb begin
    w_status          = '0;
    w_status.count    = sat_count8(9'(w_count));
    w_status.overflow = r_overflow;
    w_status.valid    = !w_empty;
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      RX_DATA_OFF:   w_rdata = w_empty ? '0 : DATA_WIDTH'(w_head);
      RX_STATUS_OFF: w_rdata = DATA_WIDTH'(w_status);
`ifdef MOCK_UART_RX_IRQ_EN
      RX_CTRL_OFF:   w_rdata = DATA_WIDTH'(r_irq_en);
`endif
      default:       w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ready    <= 1'b0;
      r_rdata    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_ready <= w_hit;
      r_rdata <= w_rd ? w_rdata : '0;
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (w_ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign bus.M_DEVICE_data_ready_o    = r_ready;
  assign bus.M_DEVICE_dev2core_data_o = r_rdata;
  assign bus.host_ready_o             = !w_full;

endmodule

// File: tb/tb_mock_uart_rx.sv
// tb/tb_mock_uart_rx.sv - directed scoreboard bench for mock_uart_rx
module tb_mock_uart_rx;
  import mock_uart_rx_pkg::*;

  localparam logic [31:0] BASE = 32'hC000_0100;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          chk_data;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  exp_t  sb[$];
  string sb_tag[$];
  exp_t  mon_e;
  string mon_tag;
`ifdef MOCK_UART_RX_IRQ_EN
  logic  irq;
`endif

  mock_uart_rx_if #(.DATA_WIDTH(32)) bus ();

  mock_uart_rx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (16),
    .DATA_WIDTH (32)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef MOCK_UART_RX_IRQ_EN
    ,
    .irq_o (irq)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every response pulse must match the oldest outstanding request, one cycle after it.
  always @(negedge clk) begin
    if (bus.M_DEVICE_data_ready_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        mon_e   = sb.pop_front();
        mon_tag = sb_tag.pop_front();
        check($sformatf("%s_lat", mon_tag), 32'(cyc), 32'(mon_e.cyc));
        if (mon_e.chk_data) check(mon_tag, bus.M_DEVICE_dev2core_data_o, mon_e.data);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("missing_resp", 32'(sb.size()), 32'd0);
      sb.delete();
      sb_tag.delete();
    end
  endtask

  task automatic req(input string tag, input logic [31:0] addr, input logic rw,
                     input logic [3:0] be, input logic [31:0] wd, input logic [31:0] exp,
                     input bit inj, input logic [7:0] inj_data);
    @(posedge clk); #1;
    bus.M_DEVICE_strobe_i        = 1'b1;
    bus.M_DEVICE_addr_i          = addr;
    bus.M_DEVICE_rw_i            = rw;
    bus.M_DEVICE_byte_enable_i   = be;
    bus.M_DEVICE_core2dev_data_i = wd;
    bus.host_valid_i             = inj;
    bus.host_data_i              = inj_data;
    sb.push_back('{exp, cyc + 1, !rw});
    sb_tag.push_back(tag);
    @(posedge clk); #1;
    bus.M_DEVICE_strobe_i = 1'b0;
    bus.host_valid_i      = 1'b0;
    drain();
  endtask

  task automatic rd(input string tag, input logic [3:0] off, input logic [31:0] exp);
    req(tag, BASE + 32'(off), 1'b0, 4'h0, 32'h0, exp, 1'b0, 8'h0);
  endtask

  task automatic wr(input string tag, input logic [3:0] off, input logic [3:0] be,
                    input logic [31:0] wd);
    req(tag, BASE + 32'(off), 1'b1, be, wd, 32'h0, 1'b0, 8'h0);
  endtask

  task automatic inject(input logic [7:0] b);
    @(posedge clk); #1;
    bus.host_valid_i = 1'b1;
    bus.host_data_i  = b;
    @(posedge clk); #1;
    bus.host_valid_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    bus.M_DEVICE_strobe_i        = 1'b0;
    bus.M_DEVICE_addr_i          = '0;
    bus.M_DEVICE_rw_i            = 1'b0;
    bus.M_DEVICE_byte_enable_i   = '0;
    bus.M_DEVICE_core2dev_data_i = '0;
    bus.host_valid_i             = 1'b0;
    bus.host_data_i              = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.M_DEVICE_data_ready_o), 32'd0);
    check("rst_rdata", bus.M_DEVICE_dev2core_data_o, 32'h0);
    check("rst_host_ready", 32'(bus.host_ready_o), 32'd1);

    rd("status_empty", 4'h4, 32'h0000_0000);
    rd("rxdata_empty", 4'h0, 32'h0000_0000);
    rd("status_after_empty_pop", 4'h4, 32'h0000_0000);

    inject(8'h41);
    inject(8'h42);
    rd("status_two", 4'h4, 32'h0000_0201);
    rd("rx_41", 4'h0, 32'h0000_0041);
    rd("rx_42", 4'h0, 32'h0000_0042);
    rd("status_drained", 4'h4, 32'h0000_0000);

    for (int i = 0; i < 17; i++) inject(8'(8'h10 + i));
    rd("status_full_ovf", 4'h4, 32'h0000_1003);
    check("host_ready_full", 32'(bus.host_ready_o), 32'd0);
    wr("clr_ovf", 4'h4, 4'h1, 32'h2);
    rd("status_full_clr", 4'h4, 32'h0000_1001);

    req("pop_push_full", BASE, 1'b0, 4'h0, 32'h0, 32'h0000_0010, 1'b1, 8'hEE);
    rd("status_after_swap", 4'h4, 32'h0000_1001);

    req("clr_vs_set", BASE + 32'h4, 1'b1, 4'h1, 32'h2, 32'h0, 1'b1, 8'h99);
    rd("status_set_wins", 4'h4, 32'h0000_1003);
    wr("clr_ovf2", 4'h4, 4'h1, 32'h2);
    rd("status_clr2", 4'h4, 32'h0000_1001);

    for (int i = 1; i < 16; i++) rd($sformatf("drain_%0d", i), 4'h0, 32'(8'h10 + i));
    rd("drain_ee", 4'h0, 32'h0000_00EE);
    rd("status_empty2", 4'h4, 32'h0000_0000);

    inject(8'hA5);
    wr("wr_rxdata", 4'h0, 4'hF, 32'h5A);
    wr("wr_reserved", 4'hC, 4'hF, 32'hFFFF_FFFF);
    rd("status_one", 4'h4, 32'h0000_0101);
    rd("rd_reserved", 4'hC, 32'h0000_0000);
`ifndef MOCK_UART_RX_IRQ_EN
    wr("wr_ctrl_ignored", 4'h8, 4'h1, 32'h1);
    rd("rd_ctrl_zero", 4'h8, 32'h0000_0000);
`endif
    rd("rx_a5", 4'h0, 32'h0000_00A5);

    @(posedge clk); #1;
    bus.M_DEVICE_strobe_i = 1'b1;
    bus.M_DEVICE_addr_i   = BASE + 32'h100;
    bus.M_DEVICE_rw_i     = 1'b0;
    @(posedge clk); #1;
    bus.M_DEVICE_strobe_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.M_DEVICE_data_ready_o === 1'b1) pulses++;
    end
    check("miss_no_ready", 32'(pulses), 32'd0);

    inject(8'h77);
    @(posedge clk); #1;
    bus.M_DEVICE_strobe_i = 1'b1;
    bus.M_DEVICE_addr_i   = BASE;
    sb.push_back('{32'h0000_0077, cyc + 1, 1'b1});
    sb_tag.push_back("b2b_rx");
    @(posedge clk); #1;
    bus.M_DEVICE_addr_i = BASE + 32'h4;
    sb.push_back('{32'h0000_0000, cyc + 1, 1'b1});
    sb_tag.push_back("b2b_status");
    @(posedge clk); #1;
    bus.M_DEVICE_strobe_i = 1'b0;
    drain();

`ifdef MOCK_UART_RX_IRQ_EN
    wr("wr_ctrl", 4'h8, 4'h1, 32'h1);
    rd("rd_ctrl", 4'h8, 32'h0000_0001);
    inject(8'h55);
    pulses = 0;
    for (int i = 0; i < 3 && pulses == 0; i++) begin
      @(negedge clk);
      if (irq === 1'b1) pulses = 1;
    end
    check("irq_high", 32'(pulses), 32'd1);
    rd("rx_55", 4'h0, 32'h0000_0055);
    @(negedge clk);
    check("irq_low", 32'(irq), 32'd0);
    inject(8'h01);
    inject(8'h02);
`endif

    inject(8'h61);
    inject(8'h62);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.M_DEVICE_strobe_i = 1'b1;
    bus.M_DEVICE_addr_i   = BASE + 32'h4;
    bus.M_DEVICE_rw_i     = 1'b0;
    @(posedge clk); #1;
    bus.M_DEVICE_strobe_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.M_DEVICE_data_ready_o === 1'b1) pulses++;
    end
    check("rst_drops_req", 32'(pulses), 32'd0);
    check("rst_host_ready2", 32'(bus.host_ready_o), 32'd1);
`ifdef MOCK_UART_RX_IRQ_EN
    check("rst_irq", 32'(irq), 32'd0);
`endif
    rd("status_after_rst", 4'h4, 32'h0000_0000);
    rd("rx_after_rst", 4'h0, 32'h0000_0000);

    @(negedge clk);
    check("idle_rdata", bus.M_DEVICE_dev2core_data_o, 32'h0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
